// File: rtl/sl_tx_scheduler.sv
// sl_tx_scheduler: round-robin arbiter that feeds one 32-bit word at a time
// from four requesters into a single SL transmitter, with start/done
// watchdogs and a fixed idle gap between words.
module sl_tx_scheduler #(
  parameter int unsigned START_WAIT = 64,
  parameter int unsigned DONE_WAIT  = 4096,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  input  logic [127:0] req_data,
  input  logic [39:0]  req_config,
  output logic [3:0]   req_ready,
  output logic [3:0]   done,
  output logic [31:0]  tx_data,
  output logic [9:0]   tx_config,
  output logic         tx_send,
  input  logic         tx_busy,
  output logic [1:0]   grant_id,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_SEND       = 3'd2,
    S_WAIT_START = 3'd3,
    S_WAIT_DONE  = 3'd4,
    S_GAP        = 3'd5
  } state_e;

  localparam logic [15:0] START_LAST = 16'(START_WAIT - 1);
  localparam logic [15:0] DONE_LAST  = 16'(DONE_WAIT - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
  localparam logic [9:0]  CFG_RESET  = 10'b0100001000;

  // Round-robin pick: returns {found, index}; the requester right after ptr
  // has highest priority, ptr itself the lowest.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] valid);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (valid[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic [31:0] tx_data_q, tx_data_d;
  logic [9:0]  tx_config_q, tx_config_d;
  logic [3:0]  req_ready_q, req_ready_d;
  logic [3:0]  done_q, done_d;
  logic        tx_send_q, tx_send_d;
  logic        timeout_err_q, timeout_err_d;
  logic        busy_q, busy_d;
  logic [2:0]  pick_s;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    tx_config_d   = tx_config_q;
    req_ready_d   = 4'b0000;
    done_d        = 4'b0000;
    tx_send_d     = 1'b0;
    timeout_err_d = 1'b0;
    pick_s        = rr_pick(rr_ptr_q, req_valid);
    case (state_q)
      S_IDLE: begin
        // A busy transmitter in IDLE (foreign or residual send) blocks grants.
        if (pick_s[2] && !tx_busy) begin
          state_d     = S_LOAD;
          rr_ptr_d    = pick_s[1:0];
          grant_id_d  = pick_s[1:0];
          tx_data_d   = req_data[{pick_s[1:0], 5'b00000} +: 32];
          tx_config_d = req_config[6'(pick_s[1:0]) * 6'd10 +: 10];
          req_ready_d = 4'b0001 << pick_s[1:0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d   = S_SEND;
        tx_send_d = 1'b1;
      end
      S_SEND: begin
        state_d = S_WAIT_START;
        cnt_d   = 16'd0;
      end
      S_WAIT_START: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
          cnt_d   = 16'd0;
        end else if (cnt_q >= START_LAST) begin
          state_d       = S_GAP;
          cnt_d         = 16'd0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_GAP;
          cnt_d   = 16'd0;
          done_d  = 4'b0001 << grant_id_q;
        end else if (cnt_q >= DONE_LAST) begin
          state_d       = S_GAP;
          cnt_d         = 16'd0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      rr_ptr_q      <= 2'd3;
      grant_id_q    <= 2'd0;
      tx_data_q     <= 32'd0;
      tx_config_q   <= CFG_RESET;
      req_ready_q   <= 4'b0000;
      done_q        <= 4'b0000;
      tx_send_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      tx_config_q   <= tx_config_d;
      req_ready_q   <= req_ready_d;
      done_q        <= done_d;
      tx_send_q     <= tx_send_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign done        = done_q;
  assign tx_data     = tx_data_q;
  assign tx_config   = tx_config_q;
  assign tx_send     = tx_send_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
